// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, queue entry layout and sizing helper for the fetch stage.
package fetch_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam int DEF_PC_STEP = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] inst;
    } fetch_entry_t;

    // Counter width able to hold the value depth itself.
    function automatic int cnt_w(int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular FIFO with synchronous flush and occupancy count.
module fetch_fifo import fetch_pkg::*; #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC generator with decoupled imem request/response and a prefetch queue to decode.
module fetch_queue_if import fetch_pkg::*; #(
    parameter int              ADDR_W   = fetch_pkg::DEF_ADDR_W,
    parameter int              DATA_W   = fetch_pkg::DEF_DATA_W,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::DEF_RESET_PC,
    parameter int              PC_STEP  = fetch_pkg::DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst
);
    localparam int CW = cnt_w(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag;
    logic [EW-1:0]     head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [CW:0]       credit_used;
    logic              q_empty;
    logic              tag_empty;
    logic              req_fire;
    logic              rsp_ok;
    logic              rsp_keep;
    logic              pop;

    // Queued plus in-flight fetches never exceed DEPTH, so a response always finds room.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = rst && !branch_taken && credit_used < (CW+1)'(DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && !tag_empty;
    assign rsp_keep       = rsp_ok && drop_cnt == '0 && !branch_taken;
    assign out_valid      = !q_empty && !branch_taken;
    assign pop            = out_valid && out_ready;
    assign out_pc         = out_valid ? head[EW-1 -: ADDR_W] : '0;
    assign out_inst       = out_valid ? head[DATA_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= branch_taken ? branch_addr : req_fire ? fetch_pc + ADDR_W'(PC_STEP) : fetch_pc;
            drop_cnt <= branch_taken ? inflight - CW'(rsp_ok) :
                        (rsp_ok && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
        end
    end

    // Tags retire on every response, dropped or not, so the FIFO count is the in-flight count.
    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .din   (fetch_pc),
        .pop   (rsp_ok),
        .dout  (tag),
        .count (inflight),
        .empty (tag_empty)
    );

    fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_taken),
        .push  (rsp_keep),
        .din   ({tag + ADDR_W'(PC_STEP), imem_rsp_data}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (q_empty)
    );

    a_rsp_inflight: assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> !tag_empty)
        else $error("fetch_queue_if: response with nothing in flight");
    a_credit: assert property (@(posedge clk) disable iff (!rst) credit_used <= (CW+1)'(DEPTH))
        else $error("fetch_queue_if: credit overrun");
endmodule

// File: tb/tb_fetch_queue_if.sv
// tb_fetch_queue_if: scoreboard bench with an in-order variable-latency memory model.
module tb_fetch_queue_if;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 0;
    logic        rst = 0;
    logic        branch_taken = 0;
    logic [31:0] branch_addr = 0;
    logic        imem_req_valid;
    logic        imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    int          n_pop = 0;
    bit          rnd = 0;
    bit          ordy = 1;
    bit          rrdy = 1;
    bit          await_first = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] first_exp = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample just before the rising edge.
    task automatic tick(input logic br = 0, input logic [31:0] ba = 0);
        int d;
        @(negedge clk);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = inst_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data  = '0;
        end
        imem_req_ready = rnd ? 1'($urandom_range(0, 1)) : rrdy;
        out_ready      = rnd ? 1'($urandom_range(0, 1)) : ordy;
        branch_taken   = br;
        branch_addr    = ba;
        #4;
        if (branch_taken) begin
            chk("br_req_valid", imem_req_valid, 0);
            chk("br_out_valid", out_valid, 0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_pc);
            d = cyc + (rnd ? int'($urandom_range(1, 3)) : lat);
            if (mq_due.size() > 0 && mq_due[$] > d) d = mq_due[$];
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(d);
            sb.push_back('{pc: exp_pc + 4, inst: inst_of(exp_pc)});
            exp_pc += 4;
            n_req++;
        end
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("out_pc", out_pc, sb[0].pc);
                chk("out_inst", out_inst, sb[0].inst);
                if (out_ready) begin
                    if (await_first) begin
                        chk("first_pc", out_pc, first_exp);
                        await_first = 0;
                    end
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
        if (branch_taken) begin
            sb.delete();
            exp_pc      = branch_addr;
            await_first = 1;
            first_exp   = branch_addr + 4;
        end
        if (rnd) begin
            chk("credit_sb", sb.size() <= DEPTH, 1);
            chk("credit_mq", mq_due.size() <= DEPTH, 1);
        end
        cyc++;
    endtask

    // Asynchronous reset mid-cycle; the memory model is cleared alongside.
    task automatic do_reset(input bit check_out);
        @(negedge clk);
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        branch_taken   = 0;
        out_ready      = 0;
        #2 rst = 0;
        #1;
        if (check_out) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_inst", out_inst, 0);
        end
        mq_addr.delete();
        mq_due.delete();
        sb.delete();
        exp_pc      = RESET_PC;
        await_first = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        int p;
        int r;
        do_reset(1);
        lat = 1; rrdy = 1; ordy = 1;
        repeat (5) tick();
        p = n_pop;
        repeat (20) tick();
        chk("throughput", n_pop - p, 20);

        do_reset(0);
        ordy = 0;
        r = n_req;
        repeat (10) tick();
        chk("stall_reqs", n_req - r, 4);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_head_pc", out_pc, 32'h4);
        ordy = 1;
        p = n_pop;
        repeat (8) tick();
        chk("resume_pops", n_pop - p >= 4, 1);

        do_reset(0);
        lat = 3;
        repeat (2) tick();
        tick(1, 32'h100);
        repeat (12) tick();
        chk("br1_first_seen", await_first, 0);

        do_reset(0);
        repeat (2) tick();
        tick(1, 32'h100);
        tick(1, 32'h200);
        repeat (14) tick();
        chk("br2_first_seen", await_first, 0);

        do_reset(0);
        rnd = 1;
        p = n_pop;
        for (int i = 0; i < 1000; i++) begin
            logic b;
            b = $urandom_range(0, 49) == 0;
            tick(b, 32'($urandom_range(0, 1023)) << 2);
        end
        rnd = 0; rrdy = 0; ordy = 1;
        repeat (20) tick();
        chk("rand_pops", n_pop - p > 100, 1);
        chk("drain_sb", sb.size(), 0);
        chk("drain_mq", mq_due.size(), 0);

        do_reset(0);
        lat = 1; rrdy = 1; ordy = 0;
        repeat (8) tick();
        chk("full_valid", out_valid, 1);
        chk("full_stall", imem_req_valid, 0);
        do_reset(1);
        ordy = 1;
        r = n_req;
        repeat (6) tick();
        chk("post_rst_reqs", n_req - r >= 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
